// File: rtl/parity_pkg.sv
// Shared definitions for the parity accumulator: FSM state encoding and
// the even/odd parity-sense constants.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/xor_reduce_n.sv
// Column XOR datapath: folds a word into the running column (or starts a
// fresh column) and reduces the current column to a single parity bit.
module xor_reduce_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] col_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] xor_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] base_s;

  // Select the column seed and combine it with the incoming word
  always_comb begin
    base_s = col_i;
    if (clear_i) begin
      base_s = '0;
    end else begin
      base_s = col_i;
    end
    xor_o    = base_s ^ word_i;
    parity_o = ^col_i;
  end

endmodule : xor_reduce_n

// File: rtl/parity_accumulator.sv
// Frame-level parity accumulator: XORs every accepted word of a frame into a
// column register and presents column, parity, count and overflow until consumed.
module parity_accumulator
  import parity_pkg::*;
#(
  parameter int   WIDTH = 32,
  parameter int   CNT_W = 8,
  parameter logic ODD   = PARITY_EVEN
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  input  logic             InLast,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutColumn,
  output logic             OutParity,
  output logic [CNT_W-1:0] OutCount,
  output logic             OutOverflow
);

  localparam logic [CNT_W-1:0] MAX_WORDS = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] col_xor_s;
  logic             col_par_s;
  logic             accept_s;

  assign InReady  = (state_q != ST_HOLD);
  assign accept_s = InValid & InReady;

  xor_reduce_n #(
    .WIDTH (WIDTH)
  ) u_xor (
    .col_i    (col_q),
    .word_i   (InData),
    .clear_i  (state_q == ST_IDLE),
    .xor_o    (col_xor_s),
    .parity_o (col_par_s)
  );

  // Next-state, column, counter and overflow logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          col_d   = col_xor_s;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = InLast ? ST_HOLD : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          col_d   = col_xor_s;
          state_d = InLast ? ST_HOLD : ST_ACCUM;
          // Saturate the count; the word still folds into the column
          if (cnt_q == MAX_WORDS) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (OutReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign OutValid    = (state_q == ST_HOLD);
  assign OutColumn   = col_q;
  assign OutCount    = cnt_q;
  assign OutOverflow = ovf_q;
  assign OutParity   = col_par_s ^ ODD;

endmodule : parity_accumulator

// File: tb/tb_parity_accumulator.sv
// Directed and randomised-handshake bench for parity_accumulator; instance 0 is
// WIDTH=8/CNT_W=8/even parity, instance 1 is WIDTH=8/CNT_W=2/odd parity.
module tb_parity_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid [2];
  logic       in_last  [2];
  logic [7:0] in_data  [2];
  logic       out_ready[2];
  logic       in_ready [2];
  logic       out_valid[2];
  logic [7:0] out_col  [2];
  logic       out_par  [2];
  logic       out_ovf  [2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  parity_accumulator #(.WIDTH(8), .CNT_W(8), .ODD(1'b0)) dut0 (
    .Clk(clk), .Reset(rst), .InValid(in_valid[0]), .InReady(in_ready[0]),
    .InData(in_data[0]), .InLast(in_last[0]), .OutValid(out_valid[0]),
    .OutReady(out_ready[0]), .OutColumn(out_col[0]), .OutParity(out_par[0]),
    .OutCount(cnt0), .OutOverflow(out_ovf[0])
  );

  parity_accumulator #(.WIDTH(8), .CNT_W(2), .ODD(1'b1)) dut1 (
    .Clk(clk), .Reset(rst), .InValid(in_valid[1]), .InReady(in_ready[1]),
    .InData(in_data[1]), .InLast(in_last[1]), .OutValid(out_valid[1]),
    .OutReady(out_ready[1]), .OutColumn(out_col[1]), .OutParity(out_par[1]),
    .OutCount(cnt1), .OutOverflow(out_ovf[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] count_of(input int idx);
    return (idx == 0) ? cnt0 : {6'd0, cnt1};
  endfunction

  // Present one word and return one step after the edge that accepted it
  task automatic send(input int idx, input logic [7:0] d, input logic last);
    int budget = 50;
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    in_last[idx]  = last;
    while (!in_ready[idx] && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check_eq("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid[idx] = 1'b0;
    in_last[idx]  = 1'b0;
  endtask

  task automatic consume(input int idx);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    logic [7:0] model_col;
    int         nwords;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_last[i] = 1'b0; in_data[i] = 8'h00; out_ready[i] = 1'b0;
    end
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", 64'(out_valid[0]), 64'd0);
    check_eq("rst_ready", 64'(in_ready[0]), 64'd1);
    check_eq("rst_col", 64'(out_col[0]), 64'd0);
    check_eq("rst_cnt", 64'(cnt0), 64'd0);
    check_eq("rst_ovf", 64'(out_ovf[0]), 64'd0);

    // Three-word even-parity frame, result one cycle after last accept
    send(0, 8'h0F, 1'b0);
    check_eq("acc_valid", 64'(out_valid[0]), 64'd0);
    send(0, 8'hF0, 1'b0);
    send(0, 8'h01, 1'b1);
    check_eq("f3_valid", 64'(out_valid[0]), 64'd1);
    check_eq("f3_col", 64'(out_col[0]), 64'hFE);
    check_eq("f3_par", 64'(out_par[0]), 64'd1);
    check_eq("f3_cnt", 64'(cnt0), 64'd3);
    check_eq("f3_ovf", 64'(out_ovf[0]), 64'd0);

    // Backpressure in HOLD with a word waiting upstream
    in_valid[0] = 1'b1; in_data[0] = 8'h55; in_last[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("hold_ready", 64'(in_ready[0]), 64'd0);
      check_eq("hold_valid", 64'(out_valid[0]), 64'd1);
      check_eq("hold_col", 64'(out_col[0]), 64'hFE);
      check_eq("hold_cnt", 64'(cnt0), 64'd3);
    end
    consume(0);
    check_eq("cons_valid", 64'(out_valid[0]), 64'd0);
    check_eq("cons_ready", 64'(in_ready[0]), 64'd1);
    check_eq("idle_keep_col", 64'(out_col[0]), 64'hFE);
    tick();
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check_eq("next_valid", 64'(out_valid[0]), 64'd1);
    check_eq("next_col", 64'(out_col[0]), 64'h55);
    check_eq("next_cnt", 64'(cnt0), 64'd1);
    consume(0);

    // Odd parity, single zero word
    send(1, 8'h00, 1'b1);
    check_eq("odd_valid", 64'(out_valid[1]), 64'd1);
    check_eq("odd_col", 64'(out_col[1]), 64'h00);
    check_eq("odd_par", 64'(out_par[1]), 64'd1);
    check_eq("odd_cnt", 64'(count_of(1)), 64'd1);
    consume(1);

    // Counter saturation with CNT_W=2
    for (int w = 0; w < 5; w++) send(1, 8'h01, (w == 4) ? 1'b1 : 1'b0);
    check_eq("sat_cnt", 64'(count_of(1)), 64'd3);
    check_eq("sat_ovf", 64'(out_ovf[1]), 64'd1);
    check_eq("sat_col", 64'(out_col[1]), 64'h01);
    check_eq("sat_par", 64'(out_par[1]), 64'd0);
    consume(1);
    send(1, 8'h03, 1'b1);
    check_eq("sat_next_ovf", 64'(out_ovf[1]), 64'd0);
    check_eq("sat_next_cnt", 64'(count_of(1)), 64'd1);
    check_eq("sat_next_col", 64'(out_col[1]), 64'h03);
    consume(1);

    // Reset mid-frame, with a competing last-word accept in the same cycle
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    rst = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h44; in_last[0] = 1'b1;
    tick();
    rst = 1'b0; in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check_eq("abort_valid", 64'(out_valid[0]), 64'd0);
    check_eq("abort_col", 64'(out_col[0]), 64'd0);
    check_eq("abort_cnt", 64'(cnt0), 64'd0);
    check_eq("abort_ready", 64'(in_ready[0]), 64'd1);
    tick(); tick();
    check_eq("abort_quiet", 64'(out_valid[0]), 64'd0);
    send(0, 8'hAA, 1'b1);
    check_eq("abort_new_col", 64'(out_col[0]), 64'hAA);
    check_eq("abort_new_cnt", 64'(cnt0), 64'd1);
    check_eq("abort_new_par", 64'(out_par[0]), 64'd0);
    consume(0);

    // Random gaps and backpressure against a reference XOR model
    for (int f = 0; f < 1000; f++) begin
      model_col = 8'h00;
      nwords = $urandom_range(1, 6);
      for (int w = 0; w < nwords; w++) begin
        logic [7:0] d;
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_data[0] = 8'($urandom);
          in_last[0] = 1'($urandom);
          tick();
        end
        d = 8'($urandom);
        model_col = model_col ^ d;
        send(0, d, (w == nwords - 1) ? 1'b1 : 1'b0);
      end
      for (int g = 0; g < $urandom_range(0, 3); g++) tick();
      check_eq("rnd_valid", 64'(out_valid[0]), 64'd1);
      check_eq("rnd_col", 64'(out_col[0]), 64'(model_col));
      check_eq("rnd_cnt", 64'(cnt0), 64'(nwords));
      check_eq("rnd_par", 64'(out_par[0]), 64'(^model_col));
      consume(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_parity_accumulator
